ysyx_22041207_axi_rd_resp: RTL and testbench

YSYX_22041207_AXI_RD_RESP -- requirements
Module: ysyx_22041207_axi_rd_resp

---
 rtl/ysyx_22041207_axi_rd_resp_pkg.sv | 40 ++++
 rtl/ysyx_22041207_req_slot.sv | 29 ++
 rtl/ysyx_22041207_axi_rd_resp.sv | 128 ++++++++++++
 tb/tb_ysyx_22041207_axi_rd_resp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_axi_rd_resp_pkg.sv
// Shared definitions for the AXI-style read responder and its sibling units
// (fetch, load/store): default memory window, read FSM state encoding, the
// packed read-request record, and small helpers for lane masking and window
// checks.
package ysyx_22041207_axi_rd_resp_pkg;

  localparam logic [63:0] MEM_BASE_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MEM_SIZE_DEFAULT = 64'h0000_0000_0800_0000;

  // Read FSM encoding, shared verbatim with the fetch and load/store units.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  mask;
  } rd_req_t;

  localparam int unsigned REQ_W = $bits(rd_req_t);

  // Keep only the bytes whose mask bit is set.
  function automatic logic [63:0] lane_mask(input logic [63:0] data,
                                            input logic [7:0]  mask);
    logic [63:0] res;
    res = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (mask[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // Subtract-then-compare so base+size never has to be formed (no wrap).
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/ysyx_22041207_req_slot.sv
// One-entry request buffer used as the responder's pending slot.
// Ports: clk, rst (async, active-high), push/push_data load the entry,
// pop empties it, full flags an occupied entry, data is the stored request.
// Push takes priority over pop; the owner never issues both at once.
module ysyx_22041207_req_slot
  import ysyx_22041207_axi_rd_resp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [REQ_W-1:0] push_data,
  output logic             full,
  output logic [REQ_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_22041207_axi_rd_resp.sv
// Fixed-latency read responder in front of a combinational backing memory.
// Ports: clk/rst (async, active-high); rx_r_valid_i/rx_r_ready_o with
// rx_r_addr_i/rx_r_size_i form the address channel; rx_data_valid/
// rx_data_ready with rx_data_read_o/rx_resp_err form the response channel;
// mem_rd_en_o/mem_addr_o/mem_rdata_i reach the backing memory.
// One request is in flight, a second may wait in the pending slot.
module ysyx_22041207_axi_rd_resp
  import ysyx_22041207_axi_rd_resp_pkg::*;
#(
  parameter int unsigned LATENCY  = 2,
  parameter logic [63:0] MEM_BASE = MEM_BASE_DEFAULT,
  parameter logic [63:0] MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_r_valid_i,
  output logic        rx_r_ready_o,
  input  logic [63:0] rx_r_addr_i,
  input  logic [7:0]  rx_r_size_i,
  output logic        rx_data_valid,
  input  logic        rx_data_ready,
  output logic [63:0] rx_data_read_o,
  output logic        rx_resp_err,
  output logic        mem_rd_en_o,
  output logic [63:0] mem_addr_o,
  input  logic [63:0] mem_rdata_i
);

  localparam logic [3:0] CNT_START = 4'(LATENCY - 1);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [63:0]      cur_addr;
  logic [7:0]       cur_mask;

  logic             slot_full;
  logic             slot_push;
  logic             slot_pop;
  logic [REQ_W-1:0] slot_data;
  rd_req_t          slot_req;
  rd_req_t          new_req;

  logic             accept;
  logic             resp_hs;
  logic             fire;
  logic             cur_ok;

  assign rx_r_ready_o = !rst && ((state == ST_IDLE) || !slot_full);
  assign accept       = rx_r_valid_i && rx_r_ready_o;
  assign resp_hs      = rx_data_valid && rx_data_ready;
  assign fire         = (state == ST_WAIT) && (cnt == '0);
  assign cur_ok       = in_window(cur_addr, MEM_BASE, MEM_SIZE);
  assign mem_rd_en_o  = fire && cur_ok;
  assign mem_addr_o   = {cur_addr[63:3], 3'b000};

  assign new_req.addr = rx_r_addr_i;
  assign new_req.mask = rx_r_size_i;
  assign slot_req     = rd_req_t'(slot_data);

  // A new address bypasses the slot when it arrives in IDLE, or in RESP on
  // the same edge the response is taken (slot is necessarily empty then,
  // since a full slot drops ready). Otherwise it parks in the slot.
  assign slot_push = accept && (state != ST_IDLE) && !((state == ST_RESP) && resp_hs);
  assign slot_pop  = (state == ST_RESP) && resp_hs && slot_full;

  ysyx_22041207_req_slot u_slot (
    .clk       (clk),
    .rst       (rst),
    .push      (slot_push),
    .pop       (slot_pop),
    .push_data (new_req),
    .full      (slot_full),
    .data      (slot_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      cur_addr       <= '0;
      cur_mask       <= '0;
      rx_data_valid  <= 1'b0;
      rx_data_read_o <= '0;
      rx_resp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur_addr <= rx_r_addr_i;
            cur_mask <= rx_r_size_i;
            cnt      <= CNT_START;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rx_data_read_o <= cur_ok ? lane_mask(mem_rdata_i, cur_mask) : '0;
            rx_resp_err    <= !cur_ok;
            rx_data_valid  <= 1'b1;
            state          <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_hs) begin
            rx_data_valid <= 1'b0;
            if (slot_full) begin
              cur_addr <= slot_req.addr;
              cur_mask <= slot_req.mask;
              cnt      <= CNT_START;
              state    <= ST_WAIT;
            end else if (accept) begin
              cur_addr <= rx_r_addr_i;
              cur_mask <= rx_r_size_i;
              cnt      <= CNT_START;
              state    <= ST_WAIT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_axi_rd_resp.sv
// Self-checking bench for ysyx_22041207_axi_rd_resp: directed scenarios then
// randomized traffic, compared each cycle against a transaction-level model
// (queue of outstanding requests with their acceptance edge).
module tb_ysyx_22041207_axi_rd_resp;

  localparam int          LAT  = 2;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SIZE = 64'h0000_0000_0800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_r_valid_i;
  logic        rx_r_ready_o;
  logic [63:0] rx_r_addr_i;
  logic [7:0]  rx_r_size_i;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [63:0] rx_data_read_o;
  logic        rx_resp_err;
  logic        mem_rd_en_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_rdata_i;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    if (a == BASE) return 64'h1122_3344_5566_7788;
    return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0] * 32'h9E37_79B1};
  endfunction

  assign mem_rdata_i = mem_model(mem_addr_o);

  ysyx_22041207_axi_rd_resp #(
    .LATENCY  (LAT),
    .MEM_BASE (BASE),
    .MEM_SIZE (SIZE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_r_valid_i   (rx_r_valid_i),
    .rx_r_ready_o   (rx_r_ready_o),
    .rx_r_addr_i    (rx_r_addr_i),
    .rx_r_size_i    (rx_r_size_i),
    .rx_data_valid  (rx_data_valid),
    .rx_data_ready  (rx_data_ready),
    .rx_data_read_o (rx_data_read_o),
    .rx_resp_err    (rx_resp_err),
    .mem_rd_en_o    (mem_rd_en_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // Reference model: outstanding requests in order, each tagged with the
  // clock edge it was accepted on. A request's service starts at the later
  // of its acceptance and the previous response handshake; data is valid
  // LAT edges after service start.
  typedef struct {
    logic [63:0] addr;
    logic [7:0]  mask;
    int          acc;
  } req_t;

  req_t q[$];
  int   last_hs = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic logic in_win(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + SIZE);
  endfunction

  function automatic logic [63:0] exp_data(input logic [63:0] a, input logic [7:0] m);
    logic [63:0] keep;
    keep = '0;
    if (!in_win(a)) return '0;
    for (int b = 0; b < 8; b++) begin
      if (m[b]) keep = keep | (64'hFF << (8 * b));
    end
    return mem_model({a[63:3], 3'b000}) & keep;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string phase);
    chk({phase, "_ready"},      64'(rx_r_ready_o),   '0);
    chk({phase, "_data_valid"}, 64'(rx_data_valid),  '0);
    chk({phase, "_resp_err"},   64'(rx_resp_err),    '0);
    chk({phase, "_rdata"},      rx_data_read_o,      '0);
    chk({phase, "_mem_rd_en"},  64'(mem_rd_en_o),    '0);
    chk({phase, "_mem_addr"},   mem_addr_o,          '0);
  endtask

  // Called at a falling edge: check outputs against the model, drive the
  // next cycle's inputs, advance the model past the coming rising edge.
  task automatic step(input logic v, input logic [63:0] a, input logic [7:0] m, input logic dr);
    logic        exp_valid;
    logic        exp_rden;
    logic        acc_now;
    logic        hs_now;
    int          due;
    logic [63:0] ha;
    logic [7:0]  hm;
    #1;
    exp_valid = 1'b0;
    exp_rden  = 1'b0;
    due       = 0;
    ha        = '0;
    hm        = '0;
    if (q.size() > 0) begin
      due       = ((q[0].acc > last_hs) ? q[0].acc : last_hs) + LAT;
      ha        = q[0].addr;
      hm        = q[0].mask;
      exp_valid = (cyc >= due);
      exp_rden  = (cyc == due - 1) && in_win(ha);
    end
    chk("ready",      64'(rx_r_ready_o),  64'(q.size() < 2));
    chk("data_valid", 64'(rx_data_valid), 64'(exp_valid));
    chk("mem_rd_en",  64'(mem_rd_en_o),   64'(exp_rden));
    if (exp_rden) chk("mem_addr", mem_addr_o, {ha[63:3], 3'b000});
    if (exp_valid) begin
      chk("rdata",    rx_data_read_o,   exp_data(ha, hm));
      chk("resp_err", 64'(rx_resp_err), 64'(!in_win(ha)));
    end
    rx_r_valid_i  = v;
    rx_r_addr_i   = a;
    rx_r_size_i   = m;
    rx_data_ready = dr;
    acc_now = v && (q.size() < 2);
    hs_now  = exp_valid && dr;
    if (hs_now) begin
      void'(q.pop_front());
      last_hs = cyc + 1;
    end
    if (acc_now) q.push_back('{a, m, cyc + 1});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    logic [63:0] ra;
    logic [7:0]  rm;
    int          kind;

    rst           = 1'b1;
    rx_r_valid_i  = 1'b0;
    rx_r_addr_i   = '0;
    rx_r_size_i   = '0;
    rx_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    last_hs = cyc;

    // single full read, partial-lane read, out-of-window read
    step(1'b1, BASE, 8'hFF, 1'b1);
    idle(5);
    step(1'b1, BASE + 64'h4, 8'h0F, 1'b1);
    idle(5);
    step(1'b1, 64'h0, 8'hFF, 1'b1);
    idle(5);

    // backpressure with a second request parked in the slot
    step(1'b1, BASE + 64'h100, 8'hFF, 1'b0);
    step(1'b1, BASE + 64'h208, 8'hF0, 1'b0);
    repeat (6) step(1'b1, BASE + 64'h310, 8'h3C, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    idle(8);

    // reset while a request is in WAIT and another is pending
    step(1'b1, BASE + 64'h40, 8'hFF, 1'b1);
    step(1'b1, BASE + 64'h48, 8'hFF, 1'b1);
    rx_r_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    last_hs = cyc;
    idle(8);

    // back-to-back reads
    step(1'b1, BASE, 8'hFF, 1'b1);
    step(1'b1, BASE + 64'h8, 8'hFF, 1'b1);
    idle(6);

    // randomized traffic including window edges
    repeat (400) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0:       ra = 64'h0;
        1:       ra = BASE - 64'h1;
        2:       ra = BASE + SIZE - 64'h1;
        3:       ra = BASE + SIZE;
        4:       ra = {$urandom, $urandom};
        default: ra = BASE + 64'($urandom_range(0, 32'h07FF_FFFF));
      endcase
      rm = 8'($urandom);
      step(1'($urandom_range(0, 1)), ra, rm, 1'($urandom_range(0, 9) < 7));
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
